// File: rtl/dsum_weighted_mac_pipe_if.sv
// Handshake bundle for the weighted MAC pipeline: the input beat on one
// side and the result stream on the other.
interface dsum_weighted_mac_pipe_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 24
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]   in_data;
  logic [NUM_CH*COEF_WIDTH-1:0]   in_coef;
  logic                           in_acc_en;
  logic                           in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [OUT_WIDTH-1:0]           out_data;
  logic                           out_sat;

  modport master (
    output in_valid, in_data, in_coef, in_acc_en, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_coef, in_acc_en, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dsum_weighted_mac_pipe.sv
// Weighted multiply-accumulate for the delay-and-sum datapath: NUM_CH signed
// sample*weight products, pipelined adder tree, optional cross-beat
// accumulation, then round-half-up, arithmetic shift and saturation.
// The whole pipeline advances on one global enable driven by the output
// handshake, so a stalled output freezes every stage.
module dsum_weighted_mac_pipe #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int MUL_STAGES = 2,
  parameter int ACC_WIDTH  = 40,
  parameter int SHIFT      = 8,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  dsum_weighted_mac_pipe_if.slave   bus
);

  localparam int PW         = DATA_WIDTH + COEF_WIDTH;
  localparam int ADD_STAGES = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int LEAVES     = 1 << ADD_STAGES;
  localparam int NSB        = MUL_STAGES + ADD_STAGES;
  localparam int RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? (ACC_WIDTH+1)'(64'sd1 <<< RND_POS) : '0;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = -OUT_MAX - 1;

  logic ce;
  logic out_valid_q;
  logic out_sat_q;
  logic [OUT_WIDTH-1:0] out_data_q;

  assign ce            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = ce;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // ---------------------------------------------------------------------
  // Input register stage
  // ---------------------------------------------------------------------
  logic                         s0_valid;
  logic                         s0_acc_en;
  logic                         s0_last;
  logic [NUM_CH*DATA_WIDTH-1:0] s0_data;
  logic [NUM_CH*COEF_WIDTH-1:0] s0_coef;

  // Capture the offered beat whenever the pipeline advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s0_valid  <= 1'b0;
      s0_acc_en <= 1'b0;
      s0_last   <= 1'b0;
    end else if (ce) begin
      s0_valid  <= bus.in_valid;
      s0_acc_en <= bus.in_acc_en;
      s0_last   <= bus.in_last;
    end
  end

  // Data path registers need no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (ce) begin
      s0_data <= bus.in_data;
      s0_coef <= bus.in_coef;
    end
  end

  // ---------------------------------------------------------------------
  // Multiplier stages
  // ---------------------------------------------------------------------
  logic signed [PW-1:0] prod_c [NUM_CH];
  logic signed [PW-1:0] mul_q  [MUL_STAGES][NUM_CH];

  // Full-width signed products, one per channel.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      prod_c[k] = PW'($signed(s0_data[k*DATA_WIDTH +: DATA_WIDTH]))
                * PW'($signed(s0_coef[k*COEF_WIDTH +: COEF_WIDTH]));
    end
  end

  // Register the products, then retime them through the remaining stages.
  always_ff @(posedge clk) begin
    if (ce) begin
      mul_q[0] <= prod_c;
      for (int unsigned s = 1; s < MUL_STAGES; s++) begin
        mul_q[s] <= mul_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Adder tree: leaves padded to a power of two with zeros, every node at
  // ACC_WIDTH so nothing is truncated inside the tree.
  // ---------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] tree_l0 [LEAVES];
  logic signed [ACC_WIDTH-1:0] sum_w;

  // Sign-extend the final multiplier outputs into the tree leaves.
  always_comb begin
    for (int unsigned i = 0; i < LEAVES; i++) begin
      tree_l0[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tree_l0[i] = ACC_WIDTH'(mul_q[MUL_STAGES-1][i]);
    end
  end

  genvar l;
  for (l = 0; l < ADD_STAGES; l++) begin : g_lvl
    localparam int N = LEAVES >> (l + 1);
    logic signed [ACC_WIDTH-1:0] q [N];
    if (l == 0) begin : g_first
      // First tree level: pairwise sum of the leaves.
      always_ff @(posedge clk) begin
        if (ce) begin
          for (int unsigned i = 0; i < N; i++) begin
            q[i] <= tree_l0[2*i] + tree_l0[2*i+1];
          end
        end
      end
    end else begin : g_next
      // Deeper tree level: pairwise sum of the previous level.
      always_ff @(posedge clk) begin
        if (ce) begin
          for (int unsigned i = 0; i < N; i++) begin
            q[i] <= g_lvl[l-1].q[2*i] + g_lvl[l-1].q[2*i+1];
          end
        end
      end
    end
  end

  if (ADD_STAGES == 0) begin : g_sum_flat
    assign sum_w = tree_l0[0];
  end else begin : g_sum_tree
    assign sum_w = g_lvl[ADD_STAGES-1].q[0];
  end

  // ---------------------------------------------------------------------
  // Sideband (valid / acc_en / last) follows the data through mul + tree
  // ---------------------------------------------------------------------
  logic [NSB-1:0] sb_valid;
  logic [NSB-1:0] sb_acc;
  logic [NSB-1:0] sb_last;

  // Shift the beat qualifiers alongside the arithmetic stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_valid <= '0;
      sb_acc   <= '0;
      sb_last  <= '0;
    end else if (ce) begin
      sb_valid[0] <= s0_valid;
      sb_acc[0]   <= s0_acc_en;
      sb_last[0]  <= s0_last;
      for (int unsigned i = 1; i < NSB; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_acc[i]   <= sb_acc[i-1];
        sb_last[i]  <= sb_last[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Accumulate / round / saturate stage
  // ---------------------------------------------------------------------
  logic                        fin_valid;
  logic                        fin_acc;
  logic                        fin_last;
  logic                        emit;
  logic                        acc_fresh;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] r;
  logic signed [ACC_WIDTH:0]   rounded;
  logic signed [ACC_WIDTH:0]   shifted;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [OUT_WIDTH-1:0]        clipped;

  assign fin_valid = sb_valid[NSB-1];
  assign fin_acc   = sb_acc[NSB-1];
  assign fin_last  = sb_last[NSB-1];

  // Form the result for the beat at the tail and decide whether it emits.
  // Rounding is done one bit wider than the accumulator so the +half
  // cannot wrap a value sitting at the positive limit.
  always_comb begin
    r       = sum_w;
    emit    = 1'b0;
    if (fin_acc) begin
      r = acc_fresh ? sum_w : acc_q + sum_w;
    end
    emit    = fin_valid && (!fin_acc || fin_last);
    rounded = (ACC_WIDTH+1)'(r) + RND;
    shifted = rounded >>> SHIFT;
    sat_hi  = shifted > OUT_MAX;
    sat_lo  = shifted < OUT_MIN;
    clipped = shifted[OUT_WIDTH-1:0];
    if (sat_hi) begin
      clipped = OUT_MAX[OUT_WIDTH-1:0];
    end else if (sat_lo) begin
      clipped = OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  // Update the running sum and the output register on each advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      acc_fresh   <= 1'b1;
    end else if (ce) begin
      out_valid_q <= emit;
      if (emit) begin
        out_data_q <= clipped;
        out_sat_q  <= sat_hi || sat_lo;
      end
      if (fin_valid && fin_acc) begin
        if (fin_last) begin
          acc_fresh <= 1'b1;
        end else begin
          acc_q     <= r;
          acc_fresh <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsum_weighted_mac_pipe.sv
// Directed bench for dsum_weighted_mac_pipe with default parameters
// (4 ch, 16x16, 2 mul stages, ACC 40, SHIFT 8, OUT 24).
module tb_dsum_weighted_mac_pipe;

  logic clk;
  logic reset;

  dsum_weighted_mac_pipe_if #(
    .NUM_CH(4), .DATA_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(24)
  ) bus ();

  dsum_weighted_mac_pipe #(
    .NUM_CH(4), .DATA_WIDTH(16), .COEF_WIDTH(16), .MUL_STAGES(2),
    .ACC_WIDTH(40), .SHIFT(8), .OUT_WIDTH(24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  longint q_data[$];
  bit     q_sat[$];

  // Record every completed output handshake.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      q_data.push_back(longint'($signed(bus.out_data)));
      q_sat.push_back(bus.out_sat);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [63:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [63:0] d, input logic [63:0] c, input bit ae, input bit lst);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_coef   = c;
    bus.in_acc_en = ae;
    bus.in_last   = lst;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 100 && q_data.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (q_data.size() < n) chk("output_timeout", q_data.size(), n);
  endtask

  task automatic expect_one(input string tag, input logic [63:0] d, input logic [63:0] c,
                            input longint ed, input bit es);
    q_data.delete();
    q_sat.delete();
    send(d, c, 1'b0, 1'b0);
    wait_outs(1);
    if (q_data.size() >= 1) begin
      chk(tag, q_data[0], ed);
      chk({tag, "_sat"}, longint'(q_sat[0]), longint'(es));
    end
  endtask

  logic [63:0] basic_d;
  logic [63:0] basic_c;
  logic [63:0] c256;
  int          lat;
  longint      head;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    basic_d = pk(256, 256, 256, 256);
    basic_c = pk(256, 256, 256, 256);
    c256    = pk(256, 0, 0, 0);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_coef   = '0;
    bus.in_acc_en = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Basic beat with exact latency measurement
    bus.in_valid  = 1'b1;
    bus.in_data   = basic_d;
    bus.in_coef   = basic_c;
    bus.in_acc_en = 1'b0;
    bus.in_last   = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) break;
    end
    chk("basic_latency", lat, 6);
    chk("basic_data", longint'($signed(bus.out_data)), 1024);
    chk("basic_sat", bus.out_sat, 0);
    repeat (3) @(posedge clk);
    #1;

    // Saturation and rounding boundaries
    expect_one("sat_pos", pk(-32768, -32768, -32768, -32768),
               pk(-32768, -32768, -32768, -32768), 8388607, 1'b1);
    expect_one("neg_nosat", pk(-32768, 0, 0, 0), pk(32767, 0, 0, 0), -4194176, 1'b0);
    expect_one("sat_neg", pk(-32768, -32768, -32768, -32768),
               pk(32767, 32767, 32767, 32767), -8388608, 1'b1);
    expect_one("rnd_half_up", pk(1, 0, 0, 0), pk(128, 0, 0, 0), 1, 1'b0);
    expect_one("rnd_neg_half", pk(-1, 0, 0, 0), pk(128, 0, 0, 0), 0, 1'b0);
    expect_one("rnd_neg_past", pk(-1, 0, 0, 0), pk(129, 0, 0, 0), -1, 1'b0);

    // Accumulation group of 3, then fresh single-beat group
    q_data.delete();
    q_sat.delete();
    send(basic_d, basic_c, 1'b1, 1'b0);
    send(basic_d, basic_c, 1'b1, 1'b0);
    send(basic_d, basic_c, 1'b1, 1'b1);
    send(basic_d, basic_c, 1'b1, 1'b1);
    wait_outs(2);
    repeat (10) @(posedge clk);
    #1;
    chk("acc_count", q_data.size(), 2);
    if (q_data.size() >= 2) begin
      chk("acc_group3", q_data[0], 3072);
      chk("acc_fresh", q_data[1], 1024);
    end

    // Pass-through beat (with last set, which must be ignored) inside a group
    q_data.delete();
    q_sat.delete();
    send(pk(1, 0, 0, 0), c256, 1'b1, 1'b0);
    send(pk(5, 0, 0, 0), c256, 1'b0, 1'b1);
    send(pk(2, 0, 0, 0), c256, 1'b1, 1'b1);
    wait_outs(2);
    if (q_data.size() >= 2) begin
      chk("interleave_pass", q_data[0], 5);
      chk("interleave_group", q_data[1], 3);
    end

    // Backpressure: stream 1..10 with a 4-cycle output stall
    repeat (10) @(posedge clk);
    #1;
    q_data.delete();
    q_sat.delete();
    fork
      begin
        for (int n = 1; n <= 10; n++) send(pk(n, 0, 0, 0), c256, 1'b0, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        head = longint'(q_data.size()) + 1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", bus.in_ready, 0);
          chk("bp_valid_held", bus.out_valid, 1);
          chk("bp_data_held", longint'($signed(bus.out_data)), head);
        end
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end
    join
    wait_outs(10);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", q_data.size(), 10);
    for (int i = 0; i < 10 && i < q_data.size(); i++) begin
      chk($sformatf("bp_order_%0d", i + 1), q_data[i], i + 1);
    end

    // Reset with a group open and beats in flight
    send(basic_d, basic_c, 1'b1, 1'b0);
    send(basic_d, basic_c, 1'b1, 1'b0);
    send(pk(7, 0, 0, 0), c256, 1'b0, 1'b0);
    send(pk(7, 0, 0, 0), c256, 1'b0, 1'b0);
    reset = 1'b0;
    q_data.delete();
    q_sat.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_stale", q_data.size(), 0);
    send(basic_d, basic_c, 1'b1, 1'b1);
    wait_outs(1);
    if (q_data.size() >= 1) chk("midrst_fresh_group", q_data[0], 1024);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
